// File: rtl/ack_receiver.sv
// ack_receiver: host-side parser for ICE ACK/NAK response frames.
// Frame layout: type (0x00 ACK / 0x01 NAK), EID, length, then <length> payload bytes.
// The decoded header is held on result_* until result_ack. One outstanding
// request EID is tracked so mismatched responses can be flagged.
// Optional feature: define ACK_RX_TIMEOUT_EN to build the response timeout
// counter; without it, timeout is tied low and only a result clears outstanding.
module ack_receiver #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] message_data,
  input  logic       message_data_valid,
  input  logic       message_frame_valid,
  output logic       message_wait,
  input  logic       expect_ack,
  input  logic [7:0] expect_eid,
  output logic       result_valid,
  output logic       result_is_nak,
  output logic [7:0] result_eid,
  output logic [7:0] result_len,
  output logic       result_eid_mismatch,
  input  logic       result_ack,
  output logic       outstanding,
  output logic       frame_error,
  output logic [7:0] error_count,
  output logic       timeout
);

  typedef enum logic [2:0] {
    S_TYPE,
    S_EID,
    S_LEN,
    S_PAYLOAD,
    S_DRAIN
  } state_t;

  state_t     state_reg, state_next;
  logic       type_nak_reg, type_nak_next;
  logic [7:0] hdr_eid_reg, hdr_eid_next;
  logic [7:0] count_reg, count_next;
  logic       drain_armed_reg, drain_armed_next;
  logic       frame_error_reg, frame_error_next;
  logic [7:0] error_count_reg, error_count_next;
  logic       result_valid_reg, result_valid_next;
  logic       result_is_nak_reg, result_is_nak_next;
  logic [7:0] result_eid_reg, result_eid_next;
  logic [7:0] result_len_reg, result_len_next;
  logic       mismatch_reg, mismatch_next;
  logic       outstanding_reg, outstanding_next;
  logic [7:0] expected_eid_reg, expected_eid_next;
  logic       timeout_reg;
  logic       timeout_hit;
  logic       acc;
  logic       load;

  // Stall only while a new LEN byte would overwrite an unconsumed result.
  assign message_wait = (state_reg == S_LEN) && result_valid_reg && !result_ack;
  assign acc          = message_data_valid && message_frame_valid && !message_wait;
  assign load         = (state_reg == S_LEN) && acc;

  // Frame parser: next state, header capture, payload countdown, error detection.
  always_comb begin
    state_next       = state_reg;
    type_nak_next    = type_nak_reg;
    hdr_eid_next     = hdr_eid_reg;
    count_next       = count_reg;
    drain_armed_next = drain_armed_reg;
    frame_error_next = 1'b0;
    case (state_reg)
      S_TYPE: begin
        if (acc) begin
          if (message_data[7:1] == 7'd0) begin
            type_nak_next = message_data[0];
            state_next    = S_EID;
          end else begin
            // Unknown frame types are skipped silently.
            drain_armed_next = 1'b0;
            state_next       = S_DRAIN;
          end
        end
      end
      S_EID: begin
        if (!message_frame_valid) begin
          frame_error_next = 1'b1;
          state_next       = S_TYPE;
        end else if (acc) begin
          hdr_eid_next = message_data;
          state_next   = S_LEN;
        end
      end
      S_LEN: begin
        if (!message_frame_valid) begin
          frame_error_next = 1'b1;
          state_next       = S_TYPE;
        end else if (acc) begin
          count_next = message_data;
          if (message_data == 8'd0) begin
            drain_armed_next = 1'b1;
            state_next       = S_DRAIN;
          end else begin
            state_next = S_PAYLOAD;
          end
        end
      end
      S_PAYLOAD: begin
        if (!message_frame_valid) begin
          frame_error_next = 1'b1;
          state_next       = S_TYPE;
        end else if (acc) begin
          count_next = count_reg - 8'd1;
          if (count_reg == 8'd1) begin
            drain_armed_next = 1'b1;
            state_next       = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (!message_frame_valid) begin
          drain_armed_next = 1'b0;
          state_next       = S_TYPE;
        end else if (acc && drain_armed_reg) begin
          // Trailing bytes after a complete ACK/NAK: flag once per frame.
          frame_error_next = 1'b1;
          drain_armed_next = 1'b0;
        end
      end
      default: state_next = S_TYPE;
    endcase
  end

  // Result hand-off, outstanding request tracking and saturating error count.
  always_comb begin
    result_valid_next  = result_valid_reg;
    result_is_nak_next = result_is_nak_reg;
    result_eid_next    = result_eid_reg;
    result_len_next    = result_len_reg;
    mismatch_next      = mismatch_reg;
    outstanding_next   = outstanding_reg;
    expected_eid_next  = expected_eid_reg;
    error_count_next   = error_count_reg;

    if (load) begin
      result_valid_next  = 1'b1;
      result_is_nak_next = type_nak_reg;
      result_eid_next    = hdr_eid_reg;
      result_len_next    = message_data;
      mismatch_next      = outstanding_reg && (hdr_eid_reg != expected_eid_reg);
    end else if (result_ack) begin
      result_valid_next = 1'b0;
    end

    if (load || timeout_hit) begin
      outstanding_next = 1'b0;
    end
    // A new request issued in the same cycle as a load survives it.
    if (expect_ack) begin
      outstanding_next  = 1'b1;
      expected_eid_next = expect_eid;
    end

    if (frame_error_next && (error_count_reg != 8'hFF)) begin
      error_count_next = error_count_reg + 8'd1;
    end
  end

`ifdef ACK_RX_TIMEOUT_EN
  logic [23:0] timer_reg;

  // A result or a fresh request in the same cycle pre-empts the timeout.
  assign timeout_hit = outstanding_reg && !expect_ack && !load &&
                       (timer_reg == (TIMEOUT_CYCLES - 24'd1));

  // Response timer: restarts per request, counts while a request is pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timer_reg <= 24'd0;
    end else if (expect_ack || load || timeout_hit) begin
      timer_reg <= 24'd0;
    end else if (outstanding_reg) begin
      timer_reg <= timer_reg + 24'd1;
    end
  end
`else
  logic unused_timeout_cfg;

  assign timeout_hit        = 1'b0;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg         <= S_TYPE;
      type_nak_reg      <= 1'b0;
      hdr_eid_reg       <= 8'd0;
      count_reg         <= 8'd0;
      drain_armed_reg   <= 1'b0;
      frame_error_reg   <= 1'b0;
      error_count_reg   <= 8'd0;
      result_valid_reg  <= 1'b0;
      result_is_nak_reg <= 1'b0;
      result_eid_reg    <= 8'd0;
      result_len_reg    <= 8'd0;
      mismatch_reg      <= 1'b0;
      outstanding_reg   <= 1'b0;
      expected_eid_reg  <= 8'd0;
      timeout_reg       <= 1'b0;
    end else begin
      state_reg         <= state_next;
      type_nak_reg      <= type_nak_next;
      hdr_eid_reg       <= hdr_eid_next;
      count_reg         <= count_next;
      drain_armed_reg   <= drain_armed_next;
      frame_error_reg   <= frame_error_next;
      error_count_reg   <= error_count_next;
      result_valid_reg  <= result_valid_next;
      result_is_nak_reg <= result_is_nak_next;
      result_eid_reg    <= result_eid_next;
      result_len_reg    <= result_len_next;
      mismatch_reg      <= mismatch_next;
      outstanding_reg   <= outstanding_next;
      expected_eid_reg  <= expected_eid_next;
      timeout_reg       <= timeout_hit;
    end
  end

  assign result_valid        = result_valid_reg;
  assign result_is_nak       = result_is_nak_reg;
  assign result_eid          = result_eid_reg;
  assign result_len          = result_len_reg;
  assign result_eid_mismatch = mismatch_reg;
  assign outstanding         = outstanding_reg;
  assign frame_error         = frame_error_reg;
  assign error_count         = error_count_reg;
  assign timeout             = timeout_reg;

endmodule

// File: tb/tb_ack_receiver.sv
// Testbench for ack_receiver: scoreboard of expected results, one task per scenario.
module tb_ack_receiver;

  logic       clk;
  logic       reset;
  logic [7:0] message_data;
  logic       message_data_valid;
  logic       message_frame_valid;
  logic       message_wait;
  logic       expect_ack;
  logic [7:0] expect_eid;
  logic       result_valid;
  logic       result_is_nak;
  logic [7:0] result_eid;
  logic [7:0] result_len;
  logic       result_eid_mismatch;
  logic       result_ack;
  logic       outstanding;
  logic       frame_error;
  logic [7:0] error_count;
  logic       timeout;

  typedef struct packed {
    logic       nak;
    logic [7:0] eid;
    logic [7:0] len;
    logic       mis;
  } exp_t;

  exp_t exp_q[$];
  int   checks;
  int   errors;
  int   fe_seen;
  int   result_no;
  logic prev_valid;

  ack_receiver #(.TIMEOUT_CYCLES(24'd100)) dut (
    .clk                 (clk),
    .reset               (reset),
    .message_data        (message_data),
    .message_data_valid  (message_data_valid),
    .message_frame_valid (message_frame_valid),
    .message_wait        (message_wait),
    .expect_ack          (expect_ack),
    .expect_eid          (expect_eid),
    .result_valid        (result_valid),
    .result_is_nak       (result_is_nak),
    .result_eid          (result_eid),
    .result_len          (result_len),
    .result_eid_mismatch (result_eid_mismatch),
    .result_ack          (result_ack),
    .outstanding         (outstanding),
    .frame_error         (frame_error),
    .error_count         (error_count),
    .timeout             (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock edge; sample 1 ns later and pop the scoreboard on each new result.
  task automatic tick();
    logic ack_at_edge;
    exp_t e;
    ack_at_edge = result_ack;
    @(posedge clk);
    #1;
    if (frame_error === 1'b1) fe_seen++;
    if (result_valid === 1'b1 && (prev_valid !== 1'b1 || ack_at_edge === 1'b1)) begin
      checks++;
      result_no++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got nak=%0b eid=%02h len=%02h mis=%0b, want no result",
                 result_is_nak, result_eid, result_len, result_eid_mismatch);
      end else begin
        e = exp_q.pop_front();
        if ({result_is_nak, result_eid, result_len, result_eid_mismatch} !== {e.nak, e.eid, e.len, e.mis}) begin
          errors++;
          $display("FAIL result_fields: got nak=%0b eid=%02h len=%02h mis=%0b, want nak=%0b eid=%02h len=%02h mis=%0b",
                   result_is_nak, result_eid, result_len, result_eid_mismatch, e.nak, e.eid, e.len, e.mis);
        end else begin
          $display("result %0d: nak=%0b eid=%02h len=%02h mis=%0b ok",
                   result_no, result_is_nak, result_eid, result_len, result_eid_mismatch);
        end
      end
    end
    prev_valid = result_valid;
  endtask

  task automatic drive_byte(input logic [7:0] b);
    message_data        = b;
    message_data_valid  = 1'b1;
    message_frame_valid = 1'b1;
    tick();
  endtask

  task automatic end_frame();
    message_data_valid  = 1'b0;
    message_frame_valid = 1'b0;
    message_data        = 8'h00;
    tick();
  endtask

  task automatic issue_request(input logic [7:0] eid);
    expect_ack = 1'b1;
    expect_eid = eid;
    tick();
    expect_ack = 1'b0;
  endtask

  task automatic ack_result();
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
  endtask

  task automatic push_exp(input logic nak, input logic [7:0] eid, input logic [7:0] len, input logic mis);
    exp_t e;
    e.nak = nak;
    e.eid = eid;
    e.len = len;
    e.mis = mis;
    exp_q.push_back(e);
  endtask

  task automatic apply_reset();
    reset               = 1'b1;
    message_data_valid  = 1'b0;
    message_frame_valid = 1'b0;
    message_data        = 8'h00;
    expect_ack          = 1'b0;
    result_ack          = 1'b0;
    exp_q.delete();
    tick();
    tick();
    reset = 1'b0;
    tick();
    fe_seen = 0;
  endtask

  task automatic check_queue_empty(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d results still expected, want 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    checks++;
    if ({message_wait, result_valid, result_is_nak, result_eid, result_len, result_eid_mismatch,
         outstanding, frame_error, error_count, timeout} !== 37'd0) begin
      errors++;
      $display("FAIL reset_outputs: got wait=%b rv=%b nak=%b eid=%h len=%h mis=%b out=%b fe=%b ec=%h to=%b, want all 0",
               message_wait, result_valid, result_is_nak, result_eid, result_len, result_eid_mismatch,
               outstanding, frame_error, error_count, timeout);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (result_valid !== 1'b0 || outstanding !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rv=%b out=%b, want 0 0", result_valid, outstanding);
    end
  endtask

  task automatic test_ack();
    issue_request(8'h5A);
    checks++;
    if (outstanding !== 1'b1) begin
      errors++;
      $display("FAIL ack_outstanding_set: got %b, want 1", outstanding);
    end
    push_exp(1'b0, 8'h5A, 8'h00, 1'b0);
    drive_byte(8'h00);
    drive_byte(8'h5A);
    drive_byte(8'h00);
    end_frame();
    checks++;
    if (outstanding !== 1'b0 || result_valid !== 1'b1) begin
      errors++;
      $display("FAIL ack_hold: got out=%b rv=%b, want out=0 rv=1", outstanding, result_valid);
    end
    ack_result();
    checks++;
    if (result_valid !== 1'b0) begin
      errors++;
      $display("FAIL ack_clear: got rv=%b, want 0", result_valid);
    end
    check_queue_empty("ack");
  endtask

  task automatic test_nak();
    issue_request(8'h34);
    push_exp(1'b1, 8'h33, 8'h02, 1'b1);
    drive_byte(8'h01);
    drive_byte(8'h33);
    drive_byte(8'h02);
    drive_byte(8'hAA);
    drive_byte(8'hBB);
    end_frame();
    checks++;
    if (fe_seen !== 0) begin
      errors++;
      $display("FAIL nak_no_frame_error: got %0d pulses, want 0", fe_seen);
    end
    ack_result();
    check_queue_empty("nak");
  endtask

  task automatic test_back_to_back();
    push_exp(1'b0, 8'h11, 8'h00, 1'b0);
    drive_byte(8'h00);
    drive_byte(8'h11);
    drive_byte(8'h00);
    end_frame();
    push_exp(1'b1, 8'h22, 8'h00, 1'b0);
    drive_byte(8'h01);
    drive_byte(8'h22);
    message_data       = 8'h00;
    message_data_valid = 1'b1;
    #1;
    checks++;
    if (message_wait !== 1'b1) begin
      errors++;
      $display("FAIL b2b_wait_asserted: got %b, want 1", message_wait);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (message_wait !== 1'b1 || result_eid !== 8'h11) begin
        errors++;
        $display("FAIL b2b_held: got wait=%b eid=%02h, want wait=1 eid=11", message_wait, result_eid);
      end
    end
    result_ack = 1'b1;
    #1;
    checks++;
    if (message_wait !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait_release: got %b, want 0", message_wait);
    end
    tick();
    result_ack = 1'b0;
    checks++;
    if (result_valid !== 1'b1) begin
      errors++;
      $display("FAIL b2b_valid_kept: got %b, want 1", result_valid);
    end
    end_frame();
    ack_result();
    checks++;
    if (result_valid !== 1'b0 || fe_seen !== 0) begin
      errors++;
      $display("FAIL b2b_final: got rv=%b fe=%0d, want rv=0 fe=0", result_valid, fe_seen);
    end
    check_queue_empty("b2b");
  endtask

  task automatic test_truncated();
    apply_reset();
    drive_byte(8'h00);
    drive_byte(8'h12);
    end_frame();
    checks++;
    if (frame_error !== 1'b1 || error_count !== 8'd1 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL trunc_first: got fe=%b ec=%02h rv=%b, want fe=1 ec=01 rv=0", frame_error, error_count, result_valid);
    end
    tick();
    checks++;
    if (frame_error !== 1'b0) begin
      errors++;
      $display("FAIL trunc_pulse_width: got %b, want 0", frame_error);
    end
    for (int i = 1; i < 300; i++) begin
      drive_byte(8'h00);
      drive_byte(8'h12);
      end_frame();
    end
    checks++;
    if (error_count !== 8'hFF || fe_seen !== 300) begin
      errors++;
      $display("FAIL trunc_saturate: got ec=%02h pulses=%0d, want ec=ff pulses=300", error_count, fe_seen);
    end
    check_queue_empty("trunc");
  endtask

  task automatic test_drain();
    apply_reset();
    drive_byte(8'h07);
    drive_byte(8'h01);
    drive_byte(8'h02);
    drive_byte(8'h03);
    drive_byte(8'h04);
    end_frame();
    checks++;
    if (fe_seen !== 0 || error_count !== 8'd0 || result_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_unknown_type: got fe=%0d ec=%02h rv=%b, want 0 00 0", fe_seen, error_count, result_valid);
    end
    push_exp(1'b0, 8'h10, 8'h00, 1'b0);
    drive_byte(8'h00);
    drive_byte(8'h10);
    drive_byte(8'h00);
    drive_byte(8'hEE);
    checks++;
    if (frame_error !== 1'b1) begin
      errors++;
      $display("FAIL drain_extra_pulse: got %b, want 1", frame_error);
    end
    drive_byte(8'hEF);
    end_frame();
    checks++;
    if (fe_seen !== 1 || error_count !== 8'd1) begin
      errors++;
      $display("FAIL drain_once: got pulses=%0d ec=%02h, want 1 01", fe_seen, error_count);
    end
    ack_result();
    // Truncated payload keeps the header result already delivered.
    push_exp(1'b0, 8'h44, 8'h03, 1'b0);
    drive_byte(8'h00);
    drive_byte(8'h44);
    drive_byte(8'h03);
    drive_byte(8'hAA);
    end_frame();
    checks++;
    if (frame_error !== 1'b1 || result_valid !== 1'b1 || error_count !== 8'd2) begin
      errors++;
      $display("FAIL drain_trunc_payload: got fe=%b rv=%b ec=%02h, want 1 1 02", frame_error, result_valid, error_count);
    end
    ack_result();
    check_queue_empty("drain");
  endtask

  task automatic test_timeout();
    apply_reset();
    issue_request(8'h77);
`ifdef ACK_RX_TIMEOUT_EN
    begin
      int  n;
      logic hit;
      n   = 0;
      hit = 1'b0;
      for (int i = 1; i <= 300 && !hit; i++) begin
        tick();
        if (timeout === 1'b1) begin
          hit = 1'b1;
          n   = i;
        end
      end
      checks++;
      if (n != 100) begin
        errors++;
        $display("FAIL timeout_latency: got %0d cycles, want 100", n);
      end
      checks++;
      if (outstanding !== 1'b0) begin
        errors++;
        $display("FAIL timeout_clears_outstanding: got %b, want 0", outstanding);
      end
      tick();
      checks++;
      if (timeout !== 1'b0) begin
        errors++;
        $display("FAIL timeout_pulse_width: got %b, want 0", timeout);
      end
    end
`else
    begin
      logic seen;
      seen = 1'b0;
      for (int i = 0; i < 150; i++) begin
        tick();
        if (timeout !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
        errors++;
        $display("FAIL timeout_disabled: got a timeout pulse, want none");
      end
      checks++;
      if (outstanding !== 1'b1) begin
        errors++;
        $display("FAIL timeout_disabled_outstanding: got %b, want 1", outstanding);
      end
    end
`endif
  endtask

  task automatic test_reset_mid_payload();
    apply_reset();
    issue_request(8'h09);
    push_exp(1'b0, 8'h09, 8'h05, 1'b0);
    drive_byte(8'h00);
    drive_byte(8'h09);
    drive_byte(8'h05);
    drive_byte(8'hAA);
    #2;
    reset               = 1'b1;
    message_data_valid  = 1'b0;
    message_frame_valid = 1'b0;
    #1;
    checks++;
    if ({message_wait, result_valid, result_is_nak, result_eid, result_len, result_eid_mismatch,
         outstanding, frame_error, error_count, timeout} !== 37'd0) begin
      errors++;
      $display("FAIL midreset_outputs: got rv=%b eid=%h len=%h out=%b fe=%b ec=%h, want all 0",
               result_valid, result_eid, result_len, outstanding, frame_error, error_count);
    end
    tick();
    reset = 1'b0;
    tick();
    push_exp(1'b0, 8'h61, 8'h00, 1'b0);
    drive_byte(8'h00);
    drive_byte(8'h61);
    drive_byte(8'h00);
    end_frame();
    checks++;
    if (result_eid !== 8'h61 || error_count !== 8'd0) begin
      errors++;
      $display("FAIL midreset_restart: got eid=%02h ec=%02h, want 61 00", result_eid, error_count);
    end
    ack_result();
    check_queue_empty("midreset");
  endtask

  initial begin
    checks              = 0;
    errors              = 0;
    fe_seen             = 0;
    result_no           = 0;
    prev_valid          = 1'b0;
    reset               = 1'b1;
    message_data        = 8'h00;
    message_data_valid  = 1'b0;
    message_frame_valid = 1'b0;
    expect_ack          = 1'b0;
    expect_eid          = 8'h00;
    result_ack          = 1'b0;
    test_reset();
    test_ack();
    test_nak();
    test_back_to_back();
    test_truncated();
    test_drain();
    test_timeout();
    test_reset_mid_payload();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ack_receiver.md
# ack_receiver

Host-side consumer of the ICE response byte stream: parses ACK/NAK frames (type byte, EID byte, length byte, optional payload) arriving on the message data/valid/frame interface, applies backpressure via `message_wait`, and hands a decoded result to the command sequencer through a held valid/ack handshake. It also tracks one outstanding request EID and flags mismatches, malformed frames, and optionally response timeouts.

## Interface
- `TIMEOUT_CYCLES`, 24'd1000000, cycles allowed between `expect_ack` and a result (used only with timeout feature).
- `clk` in 1 system clock.
- `reset` in 1 asynchronous, active-high reset.
- `message_data` in 8 stream byte.
- `message_data_valid` in 1 byte present.
- `message_frame_valid` in 1 high for the whole frame; low between frames.
- `message_wait` out 1 stall request to the producer; byte accepted only when valid and frame valid are high and `message_wait` is low.
- `expect_ack` in 1 one-cycle pulse: a request with `expect_eid` was issued.
- `expect_eid` in 8 EID of the issued request.
- `result_valid` out 1 decoded result held until acknowledged.
- `result_is_nak` out 1 type byte was 0x01.
- `result_eid` out 8 received EID.
- `result_len` out 8 received length byte.
- `result_eid_mismatch` out 1 request outstanding and `result_eid` != expected EID.
- `result_ack` in 1 consumer takes result; clears `result_valid` next cycle.
- `outstanding` out 1 a request awaits its response.
- `frame_error` out 1 one-cycle pulse on a malformed frame.
- `error_count` out 8 saturating count of `frame_error` pulses.
- `timeout` out 1 one-cycle pulse on response timeout.

## Operation
- States: S_TYPE, S_EID, S_LEN, S_PAYLOAD, S_DRAIN. Transitions occur on an accepted byte (`acc` = data_valid & frame_valid & !message_wait) or on frame end.
- S_TYPE: accepted 0x00/0x01 -> latch type, go S_EID; any other type -> S_DRAIN (not an error).
- S_EID: `acc` -> latch EID, go S_LEN.
- S_LEN: `acc` -> load result registers (`result_valid`=1, type, EID, length, mismatch), clear `outstanding`. Length 0 -> S_DRAIN; else load 8-bit down-counter with length, go S_PAYLOAD.
- S_PAYLOAD: each `acc` decrements the counter and discards the byte; counter reaching 0 -> S_DRAIN.
- S_DRAIN: ignores bytes; `message_frame_valid` low -> S_TYPE. Any byte accepted in S_DRAIN after a completed ACK/NAK header and payload -> `frame_error` (once per frame).
- `message_frame_valid` low while in S_EID, S_LEN or S_PAYLOAD -> `frame_error`, go S_TYPE; no result is produced for truncated headers; truncated payload keeps the already-loaded result.
- `message_wait` = S_LEN & `result_valid` & !`result_ack`; it is low in every other state. It depends only on registered state and `result_ack`, never on `message_data`.
- `result_eid_mismatch` = `outstanding` & (received EID != stored expected EID), computed at load; 0 when not outstanding.
- `expect_ack` sets `outstanding` and stores `expect_eid`; simultaneous `expect_ack` and result load -> the load uses the old expected EID and clears, then `outstanding` is set again (new request wins).
- `error_count` saturates at 8'hFF.

## Timing
- Reset (asynchronous): state S_TYPE; `message_wait`, `result_valid`, `result_is_nak`, `result_eid_mismatch`, `outstanding`, `frame_error`, `timeout` = 0; `result_eid`, `result_len`, `error_count` = 0.
- `result_valid` rises the cycle after the LEN byte is accepted; falls the cycle after `result_ack` is sampled high.
- `result_ack` and a new LEN load in the same cycle -> the new result is loaded, `result_valid` stays 1.
- Minimum frame: 3 accepted bytes in 3 consecutive cycles; back-to-back frames need one cycle of `message_frame_valid` low.
- `frame_error` and `timeout` are one-cycle pulses, registered.

## Configuration
- `ACK_RX_TIMEOUT_EN` defined: 24-bit counter cleared on `expect_ack`, increments while `outstanding`; reaching `TIMEOUT_CYCLES` pulses `timeout` and clears `outstanding`. A result loaded the same cycle wins (no timeout).
- Not defined: no counter is built, `timeout` is tied 0, `outstanding` is cleared only by a result.

## Test plan
- ACK frame 0x00, 0x5A, 0x00 with `expect_eid`=0x5A outstanding -> `result_valid`=1, `result_is_nak`=0, `result_eid`=0x5A, mismatch 0, `outstanding`=0.
- NAK frame 0x01, 0x33, 0x02, 0xAA, 0xBB with expected 0x34 -> `result_is_nak`=1, `result_len`=2, mismatch 1, no `frame_error`.
- Second frame while first result unacknowledged -> `message_wait`=1 in S_LEN, LEN byte held until `result_ack`, then second result loaded with no lost byte.
- `message_frame_valid` dropped after byte 0x00, 0x12 -> `frame_error` pulse, `error_count`=1, no `result_valid`; 300 such frames -> `error_count`=0xFF.
- Type 0x07 frame of 5 bytes -> no result, no error; extra byte after 0x00, 0x10, 0x00 -> one `frame_error`.
- With `ACK_RX_TIMEOUT_EN`, `TIMEOUT_CYCLES`=100, `expect_ack` and no response -> `timeout` pulse 100 cycles later, `outstanding`=0; reset asserted mid-payload -> all outputs 0, state S_TYPE immediately.
